// File: rtl/exp_align_if.sv
`default_nettype none
// ============================================================================
// Module   : exp_align_if
// Purpose  : Operand-in / alignment-result-out valid/ready bundle for the
//            exponent-alignment stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exp_align_if #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
);
  localparam int SHIFT_W = $clog2(MAN_WIDTH + 4);

  logic                 in_valid;
  logic                 in_ready;
  logic [EXP_WIDTH-1:0] exp_a;
  logic [EXP_WIDTH-1:0] exp_b;
  logic                 sign_a;
  logic                 sign_b;
  logic                 op_sub;

  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_WIDTH-1:0] exp_big;
  logic [SHIFT_W-1:0]   shift_amt;
  logic                 shift_sat;
  logic                 swap;
  logic                 eff_sub;
  logic [1:0]           exp_disc;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, exp_a, exp_b, sign_a, sign_b, op_sub, out_ready,
    input  in_ready, out_valid, exp_big, shift_amt, shift_sat, swap,
           eff_sub, exp_disc
  );

  // The alignment stage itself.
  modport slave (
    input  in_valid, exp_a, exp_b, sign_a, sign_b, op_sub, out_ready,
    output in_ready, out_valid, exp_big, shift_amt, shift_sat, swap,
           eff_sub, exp_disc
  );
endinterface
`default_nettype wire

// File: rtl/exp_align_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exp_align_pipe
// Purpose  : 2-stage exponent compare / alignment-shift stage for FP add/sub.
//            Optional macro EXP_ALIGN_DENORM_EN: exponent 0 aligns as 1.
// Revision : 1.0 - initial release
// ============================================================================
module exp_align_pipe #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  wire logic   clk,
  input  wire logic   rst,
  exp_align_if.slave  bus
);
  localparam int SHIFT_W = $clog2(MAN_WIDTH + 4);
  localparam int c_sat   = MAN_WIDTH + 3;
  localparam logic [EXP_WIDTH:0] c_sat_ext = (EXP_WIDTH + 1)'(c_sat);

  // Handshake / flow control
  logic w_s1_adv;
  logic w_s2_adv;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  // Stage 1: effective exponents and exact signed difference
  logic [EXP_WIDTH-1:0] w_eff_a;
  logic [EXP_WIDTH-1:0] w_eff_b;
  logic [EXP_WIDTH:0]   w_diff;

`ifdef EXP_ALIGN_DENORM_EN
  // Subnormals share the minimum normal exponent's scale.
  assign w_eff_a = (bus.exp_a == '0) ? EXP_WIDTH'(1) : bus.exp_a;
  assign w_eff_b = (bus.exp_b == '0) ? EXP_WIDTH'(1) : bus.exp_b;
`else
  assign w_eff_a = bus.exp_a;
  assign w_eff_b = bus.exp_b;
`endif

  assign w_diff = {1'b0, w_eff_a} - {1'b0, w_eff_b};

  logic [EXP_WIDTH-1:0] r_s1_eff_a;
  logic [EXP_WIDTH-1:0] r_s1_eff_b;
  logic [EXP_WIDTH:0]   r_s1_diff;
  logic                 r_s1_eff_sub;
  logic [1:0]           r_s1_disc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_eff_a   <= '0;
      r_s1_eff_b   <= '0;
      r_s1_diff    <= '0;
      r_s1_eff_sub <= 1'b0;
      r_s1_disc    <= 2'b00;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_eff_a   <= w_eff_a;
        r_s1_eff_b   <= w_eff_b;
        r_s1_diff    <= w_diff;
        r_s1_eff_sub <= bus.sign_a ^ bus.sign_b ^ bus.op_sub;
        r_s1_disc    <= {(&bus.exp_b), (&bus.exp_a)};
      end
    end
  end

  // Stage 2: magnitude, larger exponent and saturated shift
  logic                 w_borrow;
  logic [EXP_WIDTH:0]   w_absd;
  logic                 w_sat_hit;
  logic [SHIFT_W-1:0]   w_shift;
  logic [EXP_WIDTH-1:0] w_exp_big;

  assign w_borrow  = r_s1_diff[EXP_WIDTH];
  assign w_absd    = w_borrow ? (-r_s1_diff) : r_s1_diff;
  assign w_sat_hit = (w_absd > c_sat_ext);
  assign w_shift   = w_sat_hit ? SHIFT_W'(c_sat) : w_absd[SHIFT_W-1:0];
  assign w_exp_big = w_borrow ? r_s1_eff_b : r_s1_eff_a;

  logic [EXP_WIDTH-1:0] r_s2_exp_big;
  logic [SHIFT_W-1:0]   r_s2_shift;
  logic                 r_s2_sat;
  logic                 r_s2_swap;
  logic                 r_s2_eff_sub;
  logic [1:0]           r_s2_disc;

  // Data only moves on an actual S1->S2 transfer, so outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_exp_big <= '0;
      r_s2_shift   <= '0;
      r_s2_sat     <= 1'b0;
      r_s2_swap    <= 1'b0;
      r_s2_eff_sub <= 1'b0;
      r_s2_disc    <= 2'b00;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_exp_big <= w_exp_big;
        r_s2_shift   <= w_shift;
        r_s2_sat     <= w_sat_hit;
        r_s2_swap    <= w_borrow;
        r_s2_eff_sub <= r_s1_eff_sub;
        r_s2_disc    <= r_s1_disc;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.exp_big   = r_s2_exp_big;
  assign bus.shift_amt = r_s2_shift;
  assign bus.shift_sat = r_s2_sat;
  assign bus.swap      = r_s2_swap;
  assign bus.eff_sub   = r_s2_eff_sub;
  assign bus.exp_disc  = r_s2_disc;

endmodule
`default_nettype wire
